// File: rtl/datapath_sequencer.sv
// Fetch/decode/execute controller: pulls 16-bit instructions over req/ack and
// drives the register-file/ALU datapath control bus with registered outputs.
module datapath_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              instr_req,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ack,
    input  logic [15:0]       instr_data,
    output logic [15:0]       RegEnable,
    output logic [3:0]        MuxControlA,
    output logic [3:0]        MuxControlB,
    output logic              MuxControlC,
    output logic [15:0]       AluControl,
    output logic              busy,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [15:0]       ir, ir_nxt;

    logic              req_nxt, busy_nxt, halted_nxt, muxc_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       regen_nxt, alu_nxt;
    logic [3:0]        muxa_nxt, muxb_nxt;

    logic [3:0] opcode_nxt;
    logic       is_ctrl_nxt, is_imm_nxt, writes_nxt, cur_is_halt;

    assign opcode_nxt  = ir_nxt[15:12];
    assign is_ctrl_nxt = (opcode_nxt == 4'hF);
    assign is_imm_nxt  = (opcode_nxt != 4'h0) && !is_ctrl_nxt;
    // r0 is the constant-zero source, so a write targeting it is dropped.
    assign writes_nxt  = !is_ctrl_nxt && (ir_nxt[11:8] != 4'h0);
    assign cur_is_halt = (ir[15:12] == 4'hF) && (ir[7:4] == 4'h1);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = START_ADDR;
                end
            end
            // Handshake: instr_req/instr_addr stay stable until a cycle with
            // instr_ack=1; that cycle's instr_data is the word, no timeout.
            S_FETCH: begin
                if (instr_ack) begin
                    ir_nxt    = instr_data;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                pc_nxt    = pc + ADDR_W'(1);
                state_nxt = cur_is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                if (start) state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered alongside it.
    always_comb begin
        req_nxt    = 1'b0;
        addr_nxt   = '0;
        busy_nxt   = 1'b0;
        halted_nxt = 1'b0;
        regen_nxt  = '0;
        muxa_nxt   = '0;
        muxb_nxt   = '0;
        muxc_nxt   = 1'b0;
        alu_nxt    = '0;
        case (state_nxt)
            S_FETCH: begin
                req_nxt  = 1'b1;
                addr_nxt = pc_nxt;
                busy_nxt = 1'b1;
            end
            S_DECODE, S_EXEC: begin
                busy_nxt = 1'b1;
                muxa_nxt = ir_nxt[11:8];
                muxb_nxt = ir_nxt[3:0];
                muxc_nxt = is_imm_nxt;
                alu_nxt  = ir_nxt;
                if (state_nxt == S_EXEC && writes_nxt)
                    regen_nxt = 16'h0001 << ir_nxt[11:8];
            end
            S_HALT: halted_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= START_ADDR;
            ir          <= '0;
            instr_req   <= 1'b0;
            instr_addr  <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            RegEnable   <= '0;
            MuxControlA <= '0;
            MuxControlB <= '0;
            MuxControlC <= 1'b0;
            AluControl  <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ir          <= ir_nxt;
            instr_req   <= req_nxt;
            instr_addr  <= addr_nxt;
            busy        <= busy_nxt;
            halted      <= halted_nxt;
            RegEnable   <= regen_nxt;
            MuxControlA <= muxa_nxt;
            MuxControlB <= muxb_nxt;
            MuxControlC <= muxc_nxt;
            AluControl  <= alu_nxt;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: directed program scenarios plus a randomized
// program run, compared every cycle against a phase-level behavioural model.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        instr_req, instr_ack;
    logic [7:0]  instr_addr;
    logic [15:0] instr_data, RegEnable, AluControl;
    logic [3:0]  MuxControlA, MuxControlB;
    logic        MuxControlC, busy, halted;
    logic [2:0]  state_dbg;

    logic        start1, req1, muxc1, busy1, halted1;
    logic        ack1 = 1'b1;
    logic [15:0] data1 = 16'hF000;
    logic [3:0]  addr1, muxa1, muxb1;
    logic [15:0] regen1, alu1;
    logic [2:0]  state1;

    always #5 clk = ~clk;

    datapath_sequencer #(.ADDR_W(8), .START_ADDR(8'd0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_ack(instr_ack), .instr_data(instr_data),
        .RegEnable(RegEnable), .MuxControlA(MuxControlA), .MuxControlB(MuxControlB),
        .MuxControlC(MuxControlC), .AluControl(AluControl),
        .busy(busy), .halted(halted), .state_dbg(state_dbg)
    );

    datapath_sequencer #(.ADDR_W(4), .START_ADDR(4'd15)) dut_w4 (
        .clk(clk), .reset(reset), .start(start1),
        .instr_req(req1), .instr_addr(addr1),
        .instr_ack(ack1), .instr_data(data1),
        .RegEnable(regen1), .MuxControlA(muxa1), .MuxControlB(muxb1),
        .MuxControlC(muxc1), .AluControl(alu1),
        .busy(busy1), .halted(halted1), .state_dbg(state1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction memory responder ----------------
    logic [15:0] prog [256];
    int fixed_delay = 0;
    bit spurious_force = 0;
    bit spurious_rand = 0;
    bit in_fetch = 0;
    int wait_cnt = 0;
    int cur_delay = 0;

    always @(negedge clk) begin
        if (instr_req === 1'b1) begin
            if (!in_fetch) begin
                in_fetch  = 1;
                wait_cnt  = 0;
                cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end
            if (wait_cnt >= cur_delay) begin
                instr_ack  = 1'b1;
                instr_data = prog[instr_addr];
            end else begin
                instr_ack  = 1'b0;
                instr_data = 16'($urandom);
                wait_cnt++;
            end
        end else begin
            in_fetch   = 0;
            instr_ack  = spurious_force || (spurious_rand && ($urandom_range(0, 2) == 0));
            instr_data = spurious_force ? 16'hFFFF : 16'($urandom);
        end
    end

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 fetch, 2 decode, 3 execute, 4 halted
    int          m_phase;
    int          m_pc;
    logic [15:0] m_ir;
    int          n_exec = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_pc    = 0;
            m_ir    = 16'h0;
        end else begin
            case (m_phase)
                0: if (start) begin m_phase = 1; m_pc = 0; end
                1: if (instr_ack) begin m_ir = instr_data; m_phase = 2; end
                2: m_phase = 3;
                3: begin
                    n_exec++;
                    m_pc    = (m_pc + 1) % 256;
                    m_phase = (m_ir[15:12] == 4'hF && m_ir[7:4] == 4'h1) ? 4 : 1;
                end
                default: if (start) m_phase = 1;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic        e_req, e_busy, e_halt, e_muxc;
    logic [3:0]  e_muxa, e_muxb;
    logic [15:0] e_regen, e_alu;
    logic [7:0]  e_addr;
    bit          in_dx;
    int          opc, rdest;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            e_req = 0; e_busy = 0; e_halt = 0; e_muxc = 0;
            e_muxa = 0; e_muxb = 0; e_regen = 0; e_alu = 0; e_addr = 0;
            check("reset_addr", instr_addr, e_addr);
        end else begin
            opc    = m_ir[15:12];
            rdest  = m_ir[11:8];
            in_dx  = (m_phase == 2) || (m_phase == 3);
            e_req  = (m_phase == 1);
            e_busy = (m_phase >= 1) && (m_phase <= 3);
            e_halt = (m_phase == 4);
            e_muxa = in_dx ? m_ir[11:8] : 4'h0;
            e_muxb = in_dx ? m_ir[3:0] : 4'h0;
            e_muxc = in_dx && (opc >= 1) && (opc <= 14);
            e_alu  = in_dx ? m_ir : 16'h0;
            e_regen = (m_phase == 3 && opc != 15 && rdest != 0) ? 16'(2 ** rdest) : 16'h0;
            e_addr = 8'(m_pc);
            if (m_phase == 1) check("fetch_addr", instr_addr, e_addr);
            if (m_phase == 0) check("idle_addr", instr_addr, 0);
        end
        check("instr_req", instr_req, e_req);
        check("busy", busy, e_busy);
        check("halted", halted, e_halt);
        check("RegEnable", RegEnable, e_regen);
        check("MuxControlA", MuxControlA, e_muxa);
        check("MuxControlB", MuxControlB, e_muxb);
        check("MuxControlC", MuxControlC, e_muxc);
        check("AluControl", AluControl, e_alu);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph, input int budget, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (m_phase != ph && steps < budget);
        n_checks++;
        if (m_phase != ph) begin
            n_errors++;
            $display("FAIL wait_phase: phase %0d, expected %0d after %0d cycles", m_phase, ph, steps);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, instr_req, 0);
        check({tag, "_addr"}, instr_addr, 0);
        check({tag, "_regen"}, RegEnable, 0);
        check({tag, "_muxa"}, MuxControlA, 0);
        check({tag, "_muxb"}, MuxControlB, 0);
        check({tag, "_muxc"}, MuxControlC, 0);
        check({tag, "_alu"}, AluControl, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 9))
            0, 1, 2, 3: w[15:12] = 4'h0;
            4, 5, 6, 7: w[15:12] = 4'($urandom_range(1, 14));
            8: begin w[15:12] = 4'hF; w[7:4] = 4'h1; end
            default: w[15:12] = 4'hF;
        endcase
        return w;
    endfunction

    int steps;

    initial begin
        reset = 1'b0; start = 1'b0; start1 = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 16'hF000;
        prog[0] = 16'h5102;
        prog[1] = 16'h0321;
        prog[2] = 16'h5005;
        prog[3] = 16'hF010;
        prog[4] = 16'h0A00;

        repeat (2) step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // Narrow PC wraps from all-ones to zero after a NOP.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("w4_req", req1, 1);
        check("w4_addr15", addr1, 15);
        repeat (3) step();
        check("w4_wrap_addr", addr1, 0);
        check("w4_wrap_req", req1, 1);

        // Immediate add with ack in the first fetch cycle.
        fixed_delay = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_req", instr_req, 1);
        check("t1_addr", instr_addr, 0);
        wait_phase(3, 10, steps);
        check("t1_latency", steps, 2);
        check("t1_regen", RegEnable, 16'h0002);
        check("t1_muxa", MuxControlA, 1);
        check("t1_muxc", MuxControlC, 1);
        check("t1_alu", AluControl, 16'h5102);

        // Register-type with a 4-cycle wait and a stray ack in decode.
        fixed_delay = 4;
        spurious_force = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_req_hold", instr_req, 1);
            check("t3_addr_hold", instr_addr, 1);
            check("t3_no_decode", MuxControlA, 0);
        end
        step();
        check("t3_dec_req", instr_req, 0);
        check("t3_dec_regen", RegEnable, 0);
        check("t3_dec_muxa", MuxControlA, 3);
        check("t3_dec_alu", AluControl, 16'h0321);
        step();
        check("t2_regen", RegEnable, 16'h0008);
        check("t2_muxa", MuxControlA, 3);
        check("t2_muxb", MuxControlB, 1);
        check("t2_muxc", MuxControlC, 0);
        check("t2_alu", AluControl, 16'h0321);
        check("model_pc_t2", m_pc, 1);
        spurious_force = 0;
        fixed_delay = 0;

        // r0 write suppressed, then HALT and resume.
        step();
        check("t4_addr2", instr_addr, 2);
        wait_phase(3, 10, steps);
        check("t4_r0_regen", RegEnable, 0);
        check("t4_r0_alu", AluControl, 16'h5005);
        step();
        check("t4_addr3", instr_addr, 3);
        wait_phase(4, 10, steps);
        check("t4_halted", halted, 1);
        check("t4_busy", busy, 0);
        check("t4_halt_alu", AluControl, 0);
        check("model_halt_pc", m_pc, 4);
        repeat (2) step();
        check("t4_still_halted", halted, 1);
        fixed_delay = 10;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t4_resume_req", instr_req, 1);
        check("t4_resume_addr", instr_addr, 4);
        check("t4_resume_halted", halted, 0);

        // Async reset mid-fetch and mid-execute.
        step();
        reset = 1'b0;
        #1;
        check_all_zero("rst_fetch");
        step();
        reset = 1'b1;
        fixed_delay = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rst_refetch_addr", instr_addr, 0);
        check("rst_refetch_req", instr_req, 1);
        wait_phase(3, 10, steps);
        check("rst_exec_regen", RegEnable, 16'h0002);
        reset = 1'b0;
        #1;
        check_all_zero("rst_exec");
        step();
        reset = 1'b1;

        // Randomized program run.
        for (int i = 0; i < 256; i++) prog[i] = rand_instr();
        fixed_delay = -1;
        spurious_rand = 1;
        n_exec = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_phase == 0 || m_phase == 4) start = ($urandom_range(0, 3) == 0);
            else start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 699) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end
        start = 1'b0;
        n_checks++;
        if (n_exec < 200) begin
            n_errors++;
            $display("FAIL random_progress: executed %0d, expected at least 200", n_exec);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
